// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: a fixed preamble followed by a latched payload, MSB first,
// one bit per clock. All outputs decode from registered state only.
module seq_frame_tx #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned        DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic              x_out,
    output logic              valid_out,
    output logic              done
);

    localparam int unsigned MaxLen = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
    localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int unsigned PatW   = 1 << CntW;

    // Pattern padded to a power of two so the counter can index it directly.
    localparam logic [PatW-1:0] PatExt   = PatW'(PATTERN);
    localparam logic [CntW-1:0] PreLoad  = CntW'(PAT_LEN - 1);
    localparam logic [CntW-1:0] DataLoad = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPre  = 2'b01,
        StData = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = data_in;
                    cnt_d   = PreLoad;
                    state_d = StPre;
                end
            end
            StPre: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    cnt_d   = DataLoad;
                    state_d = StData;
                end
            end
            StData: begin
                shreg_d = shreg_q << 1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        x_out     = 1'b0;
        valid_out = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle: ready = 1'b1;
            StPre: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                x_out     = PatExt[cnt_q];
            end
            StData: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                x_out     = shreg_q[DATA_W-1];
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: directed scenarios plus a randomized run
// checked against a frame-level queue model.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       ready, busy, x_out, valid_out, done;
    logic       s_start;
    logic [3:0] s_data;
    logic       s_ready, s_busy, s_x, s_valid, s_done;
    logic [4:0] obs, s_obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-cycle outputs {ready,busy,x,valid,done} for the random run.
    logic [4:0] exp_q[$];

    localparam logic [4:0] IdleObs = 5'b10000;
    localparam logic [4:0] DoneObs = 5'b01001;

    always #5 clk = ~clk;

    assign obs   = {ready, busy, x_out, valid_out, done};
    assign s_obs = {s_ready, s_busy, s_x, s_valid, s_done};

    seq_frame_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .ready    (ready),
        .busy     (busy),
        .x_out    (x_out),
        .valid_out(valid_out),
        .done     (done)
    );

    seq_frame_tx #(
        .PAT_LEN(3),
        .PATTERN(3'b101),
        .DATA_W (4)
    ) dut_small (
        .clk      (clk),
        .reset    (reset),
        .start    (s_start),
        .data_in  (s_data),
        .ready    (s_ready),
        .busy     (s_busy),
        .x_out    (s_x),
        .valid_out(s_valid),
        .done     (s_done)
    );

    function automatic logic [4:0] bit_obs(input logic b);
        return {1'b0, 1'b1, b, 1'b1, 1'b0};
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        logic [11:0] fr;
        fr = {4'b1011, d};
        for (int i = 0; i < 12; i++) exp_q.push_back(bit_obs(fr[11-i]));
        exp_q.push_back(DoneObs);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (obs !== IdleObs) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", obs, IdleObs);
        end
        reset = 1'b0;
        start = 1'b1;
        data_in = 8'(($urandom));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got busy=%b want 1", busy);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== IdleObs) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs, IdleObs);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_frame_a5();
        logic [11:0] fr;
        logic [3:0]  win;
        logic        z;
        fr  = {4'b1011, 8'hA5};
        win = 4'b0000;
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'hA5;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                data_in = 8'(($urandom));
            end
            n_checks++;
            if (i < 12 && obs !== bit_obs(fr[11-i])) begin
                n_fail++;
                $display("FAIL a5_bit%0d: got %b want %b", i, obs, bit_obs(fr[11-i]));
            end else if (i == 12 && obs !== DoneObs) begin
                n_fail++;
                $display("FAIL a5_done: got %b want %b", obs, DoneObs);
            end
            if (i < 12) win = {win[2:0], x_out};
            z = (win == 4'b1011);
            if (i == 3) begin
                n_checks++;
                if (z !== 1'b1) begin
                    n_fail++;
                    $display("FAIL a5_detect: got z=%b window=%b want z=1", z, win);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (obs !== IdleObs) begin
            n_fail++;
            $display("FAIL a5_ready: got %b want %b", obs, IdleObs);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] fr;
        int          busy_cnt;
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'hFF;
        for (int f = 0; f < 2; f++) begin
            fr       = {4'b1011, (f == 0) ? 8'hFF : 8'h00};
            busy_cnt = 0;
            for (int i = 0; i < 13; i++) begin
                @(negedge clk);
                if (f == 0 && i == 0) data_in = 8'h00;
                if (busy) busy_cnt++;
                n_checks++;
                if (i < 12 && obs !== bit_obs(fr[11-i])) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_bit%0d: got %b want %b", f, i, obs, bit_obs(fr[11-i]));
                end else if (i == 12 && obs !== DoneObs) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_done: got %b want %b", f, obs, DoneObs);
                end
                if (f == 1 && i == 12) start = 1'b0;
            end
            n_checks++;
            if (busy_cnt != 13) begin
                n_fail++;
                $display("FAIL b2b_f%0d_busy_len: got %0d want 13", f, busy_cnt);
            end
            @(negedge clk);
            n_checks++;
            if (obs !== IdleObs) begin
                n_fail++;
                $display("FAIL b2b_f%0d_gap: got %b want %b", f, obs, IdleObs);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [11:0] fr;
        fr = {4'b1011, 8'h81};
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h81;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_checks++;
            if (i < 12 && obs !== bit_obs(fr[11-i])) begin
                n_fail++;
                $display("FAIL ign_bit%0d: got %b want %b", i, obs, bit_obs(fr[11-i]));
            end else if (i == 12 && obs !== DoneObs) begin
                n_fail++;
                $display("FAIL ign_done: got %b want %b", obs, DoneObs);
            end
            if (i == 4) begin
                start   = 1'b1;
                data_in = 8'h3C;
            end
            if (i == 5) start = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== IdleObs) begin
                n_fail++;
                $display("FAIL ign_idle%0d: got %b want %b", i, obs, IdleObs);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] fr;
        logic [7:0]  d;
        d  = 8'(($urandom));
        fr = {4'b1011, d};
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_checks++;
            if (obs !== bit_obs(fr[11-i])) begin
                n_fail++;
                $display("FAIL rmid_bit%0d: got %b want %b", i, obs, bit_obs(fr[11-i]));
            end
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== IdleObs) begin
            n_fail++;
            $display("FAIL rmid_abort: got %b want %b", obs, IdleObs);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== IdleObs) begin
                n_fail++;
                $display("FAIL rmid_quiet%0d: got %b want %b", i, obs, IdleObs);
            end
        end
        fr      = {4'b1011, 8'h01};
        start   = 1'b1;
        data_in = 8'h01;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_checks++;
            if (i < 12 && obs !== bit_obs(fr[11-i])) begin
                n_fail++;
                $display("FAIL rmid_re_bit%0d: got %b want %b", i, obs, bit_obs(fr[11-i]));
            end else if (i == 12 && obs !== DoneObs) begin
                n_fail++;
                $display("FAIL rmid_re_done: got %b want %b", obs, DoneObs);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_small_params();
        logic [6:0] fr;
        int         busy_cnt;
        fr       = 7'b1010110;
        busy_cnt = 0;
        @(negedge clk);
        s_start = 1'b1;
        s_data  = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                s_start = 1'b0;
                s_data  = 4'(($urandom));
            end
            if (s_busy) busy_cnt++;
            n_checks++;
            if (i < 7 && s_obs !== bit_obs(fr[6-i])) begin
                n_fail++;
                $display("FAIL small_bit%0d: got %b want %b", i, s_obs, bit_obs(fr[6-i]));
            end else if (i == 7 && s_obs !== DoneObs) begin
                n_fail++;
                $display("FAIL small_done: got %b want %b", s_obs, DoneObs);
            end
        end
        n_checks++;
        if (busy_cnt != 8) begin
            n_fail++;
            $display("FAIL small_busy_len: got %0d want 8", busy_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (s_obs !== IdleObs) begin
            n_fail++;
            $display("FAIL small_ready: got %b want %b", s_obs, IdleObs);
        end
    endtask

    task automatic test_random();
        logic [4:0] want;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            want = (exp_q.size() == 0) ? IdleObs : exp_q[0];
            n_checks++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: got %b want %b", c, obs, want);
            end
            start   = ($urandom_range(0, 3) == 0);
            data_in = 8'(($urandom));
            if (exp_q.size() == 0) begin
                if (start) push_frame(data_in);
            end else begin
                void'(exp_q.pop_front());
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        s_start = 1'b0;
        s_data  = 4'h0;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_small_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter that emits a fixed preamble pattern (default 1011) followed by a latched data word, one bit per clock, MSB first. It is the transmit end for the team's serial-pattern detectors: its x_out drives a detector's x input. Moore-style: all outputs decode from registered state and counters only; there is no combinational path from inputs to outputs.

Parameters:
PATTERN, 4'b1011, preamble bits, sent MSB first
PAT_LEN, 4, number of preamble bits (width of PATTERN), >=1
DATA_W, 8, payload width in bits, >=1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to send one frame; sampled only in IDLE
data_in  input  DATA_W  payload; latched on the accepting edge
ready  output  1  high in IDLE (start will be accepted)
busy  output  1  high in PRE, DATA and DONE
x_out  output  1  serial bit stream
valid_out  output  1  high while x_out carries a preamble or data bit
done  output  1  one-cycle pulse after the last data bit

Behaviour:
- Reset is asynchronous and active-high on clk domain; it returns the block to IDLE.
- Reset values: state=IDLE, bit counter=0, data shift register=0, ready=1, busy=0, x_out=0, valid_out=0, done=0.
- States: IDLE, PRE, DATA, DONE. State uses a 2-bit encoding. Unused encodings go to IDLE on the next edge.
- IDLE: ready=1, x_out=0, valid_out=0.
  - On an edge with start=1: latch data_in into the shift register, load cnt=PAT_LEN-1, go to PRE.
  - With start=0: stay in IDLE.
- PRE: x_out=PATTERN[cnt], valid_out=1.
  - If cnt>0: decrement cnt each edge.
  - If cnt==0: load cnt=DATA_W-1 and go to DATA.
- DATA: x_out=shreg[DATA_W-1], valid_out=1.
  - Each edge shifts shreg left by 1, filling with 0.
  - If cnt>0: decrement cnt.
  - If cnt==0: go to DONE.
- DONE: done=1, x_out=0, valid_out=0, busy=1. Next edge always goes to IDLE.
- Latency: start sampled at edge k gives the first preamble bit on x_out in the cycle after edge k.
  - Preamble occupies PAT_LEN cycles, payload DATA_W cycles, DONE 1 cycle.
  - busy is high for PAT_LEN+DATA_W+1 cycles, then ready returns.
- Minimum start-to-start spacing is PAT_LEN+DATA_W+2 edges.
- start held continuously high gives back-to-back frames with exactly one IDLE cycle (x_out=0) between DONE and the next PRE.
- start or data_in changes while busy: ignored. The payload in flight is unaffected.
- Reset mid-frame: the block enters IDLE immediately (asynchronously). The frame is aborted and not resumed. done does not pulse. x_out=0 from reset assertion onward.
- Counter width is clog2(max(PAT_LEN,DATA_W)), minimum 1 bit. No wrap: the counter is reloaded at each phase change and never decremented below 0.
- No bit stuffing: a payload containing the preamble pattern is transmitted as-is.

Test Plan:
- Assert reset mid-simulation with no clock edge -> ready=1, busy=0, x_out=0, valid_out=0, done=0 immediately.
- Default params, data_in=8'hA5, 1-cycle start pulse -> x_out over 12 valid cycles is 1,0,1,1,1,0,1,0,0,1,0,1; then done=1 for exactly 1 cycle; then ready=1. Feeding x_out to a 1011 Moore detector asserts its z after the 4th bit.
- start held high, data_in=8'hFF then 8'h00 -> two frames of 13 busy cycles each, exactly 1 IDLE cycle between them; second payload all zeros.
- Pulse start and change data_in to 8'h3C during the 5th busy cycle of an 8'h81 frame -> payload bits stay 10000001; no second frame starts.
- Assert reset during the 3rd payload bit -> x_out=0 at once, no done pulse; the next start with 8'h01 produces a complete correct frame.
- Override PATTERN=3'b101, PAT_LEN=3, DATA_W=4, data_in=4'b0110 -> x_out sequence 1,0,1,0,1,1,0; busy for 8 cycles.
